change_dispenser: RTL and testbench
===================================

# change_dispenser

Payout engine for the vending machine: accepts a change amount from the vending FSM (its `cambio` output, qualified by `listo`) and returns it as a sequence of individual coin-eject requests to the coin hopper. It is the reverse path of the coin-acceptance decoder. Coin values are 2, 3 and 4 units, the same set the vending FSM accepts. Each coin is issued with a req/ack handshake, and the block reports completion, error and any unpaid residue.

## Interface
- `AMT_W`, 5: width of the change amount, in units.
- `TIMEOUT_CYCLES`, 255: hopper-ack watchdog limit in cycles. Used only with `DISPENSE_TIMEOUT_EN`.

- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cambio` in AMT_W: change amount to pay out.
- `cambio_valid` in 1: one-cycle strobe. `cambio` is sampled only when `ready`=1.
- `ready` out 1: high when idle and able to accept an amount.
- `coin_req` out 1: coin-eject request to the hopper.
- `coin_code` out 2: coin to eject. 01 = 2 units, 10 = 3 units, 11 = 4 units, 00 = none.
- `coin_ack` in 1: hopper acknowledge (4-phase).
- `done` out 1: one-cycle pulse when a transaction ends.
- `error` out 1: valid with `done`. High if the amount was not fully paid.
- `residual` out AMT_W: unpaid units. Valid from `done` until the next accepted amount.

## Operation
- States: IDLE, SELECT, REQ, GAP, DONE.
- Reset values: state=IDLE, `rem`=0, `ready`=1, `coin_req`=0, `coin_code`=00, `done`=0, `error`=0, `residual`=0, timeout counter=0.
- IDLE:
  - `ready`=1.
  - On `cambio_valid`: `rem` <= `cambio`, `residual` <= 0, go to SELECT.
- SELECT picks one coin so that the remaining amount never becomes exactly 1:
  - If `rem`>=4 and `rem`-4 != 1: coin 4.
  - Else if `rem`>=3 and `rem`-3 != 1: coin 3.
  - Else if `rem`>=2: coin 2.
  - If a coin is chosen: `coin_code` <= choice, `coin_req` <= 1, go to REQ.
  - `rem`==0: go to DONE, `error`=0.
  - `rem`==1: go to DONE, `error`=1, `residual`=1.
  - Every amount >=2 is payable. 5 pays as 3+2, 6 as 4+2, 7 as 4+3.
- REQ:
  - `coin_req` and `coin_code` stay stable.
  - When `coin_ack`=1 is sampled: `coin_req` <= 0, `coin_code` <= 00, `rem` <= `rem` - value, go to GAP.
- GAP: wait until `coin_ack`=0 is sampled, then go to SELECT.
- DONE:
  - `done`=1 for exactly one cycle, with `error` and `residual` valid.
  - Next state is IDLE.
  - `error` is cleared on leaving DONE. `residual` holds.
- Arithmetic: `rem` is AMT_W bits and unsigned. Subtraction never underflows because of the SELECT guard.
- `cambio_valid` while `ready`=0 is ignored and the amount is lost. The upstream block must gate on `ready`.
- `coin_ack` seen outside REQ/GAP is ignored.
- Reset mid-transaction:
  - The next edge applies the reset values.
  - `coin_req` drops.
  - The remaining amount is discarded and no `done` is generated.

## Timing
- Strobe accepted at edge N. SELECT at N+1. `coin_req` visible from N+2.
- Each coin takes a minimum of 3 cycles with an ack in the same cycle as req and release one cycle later: REQ, GAP, SELECT.
- Amount 0 or 1: `done` at N+2, no `coin_req`.
- `ready` is low from N+1 through the DONE cycle. It returns high the cycle after DONE.
- Back-to-back transactions: a new strobe is accepted in the first IDLE cycle.

## Configuration
- `DISPENSE_TIMEOUT_EN` defined:
  - A counter runs while in REQ or GAP and clears on every state change.
  - When it reaches `TIMEOUT_CYCLES`: `coin_req` <= 0, go to DONE with `error`=1 and `residual`=`rem`.
  - In REQ, `rem` still includes the unacked coin. In GAP, it excludes it.
- Not defined:
  - No counter.
  - The block waits in REQ/GAP indefinitely.
  - `error` is caused only by an unpayable residue of 1.

## Test plan
- `cambio`=7, hopper acks each req after 2 cycles -> `coin_code` 11 then 10, two req/ack cycles, `done` pulse, `error`=0, `residual`=0.
- `cambio`=5 -> coins 10 then 01. `cambio`=6 -> coins 11 then 01. `cambio`=2 -> single 01.
- `cambio`=1 -> no `coin_req`, `done`=1 and `error`=1 at N+2, `residual`=1. `cambio`=0 -> `done` at N+2, `error`=0.
- Second `cambio_valid` (value 4) while dispensing 9 -> ignored. Only coins 11, 10, 01 issued (4+3+2=9). `ready` stays low until after DONE.
- `rst` asserted while `coin_req`=1 for `cambio`=9 -> next cycle `coin_req`=0, `ready`=1, no `done`. A fresh `cambio`=4 then dispenses a single 11.
- With `DISPENSE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `cambio`=7, `coin_ack` held 0 -> `coin_req` drops after 16 cycles in REQ, `done`=1, `error`=1, `residual`=7.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Bundle between the vending FSM, the change dispenser and the coin hopper.
// Handshakes: cambio_valid is a one-cycle strobe taken only while ready=1;
// coin_req/coin_ack is 4-phase (req up, ack up, req down, ack down).
interface change_dispenser_if #(
  parameter int AMT_W = 5
);
  logic [AMT_W-1:0] cambio;
  logic             cambio_valid;
  logic             ready;
  logic             coin_req;
  logic [1:0]       coin_code;
  logic             coin_ack;
  logic             done;
  logic             error;
  logic [AMT_W-1:0] residual;
  logic [2:0]       dbg_state;

  modport master (
    output cambio, cambio_valid, coin_ack,
    input  ready, coin_req, coin_code, done, error, residual, dbg_state
  );

  modport slave (
    input  cambio, cambio_valid, coin_ack,
    output ready, coin_req, coin_code, done, error, residual, dbg_state
  );
endinterface

// File: rtl/change_dispenser.sv
// Pays a change amount out as individual 2/3/4-unit coin-eject requests.
// Optional hopper-ack watchdog enabled by defining DISPENSE_TIMEOUT_EN.
module change_dispenser #(
  parameter int AMT_W          = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    REQ    = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] coin_val;
  logic [1:0]       pick;
  logic             ready_r;
  logic             coin_req_r;
  logic [1:0]       coin_code_r;
  logic             done_r;
  logic             error_r;
  logic [AMT_W-1:0] residual_r;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef DISPENSE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // Coin choice never leaves exactly 1 unit behind, so any amount >= 2 is payable.
  always_comb begin
    pick = 2'b00;
    if (rem >= AMT_W'(4) && rem != AMT_W'(5))      pick = 2'b11;
    else if (rem >= AMT_W'(3) && rem != AMT_W'(4)) pick = 2'b10;
    else if (rem >= AMT_W'(2))                     pick = 2'b01;
  end

  // Code 01/10/11 maps to 2/3/4 units.
  assign coin_val = AMT_W'(coin_code_r) + AMT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      ready_r     <= 1'b1;
      coin_req_r  <= 1'b0;
      coin_code_r <= 2'b00;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      residual_r  <= '0;
`ifdef DISPENSE_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
`ifdef DISPENSE_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (bus.cambio_valid) begin
            rem        <= bus.cambio;
            residual_r <= '0;
            ready_r    <= 1'b0;
            state      <= SELECT;
          end
        end
        SELECT: begin
          if (pick != 2'b00) begin
            coin_code_r <= pick;
            coin_req_r  <= 1'b1;
            state       <= REQ;
          end else begin
            // rem is 0 (clean finish) or 1 (unpayable residue).
            done_r     <= 1'b1;
            error_r    <= (rem != '0);
            residual_r <= rem;
            state      <= DONE;
          end
        end
        REQ: begin
          if (bus.coin_ack) begin
            coin_req_r  <= 1'b0;
            coin_code_r <= 2'b00;
            rem         <= rem - coin_val;
            state       <= GAP;
          end
`ifdef DISPENSE_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            coin_req_r  <= 1'b0;
            coin_code_r <= 2'b00;
            done_r      <= 1'b1;
            error_r     <= 1'b1;
            residual_r  <= rem;
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          if (!bus.coin_ack) begin
            state <= SELECT;
          end
`ifdef DISPENSE_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            done_r     <= 1'b1;
            error_r    <= 1'b1;
            residual_r <= rem;
            state      <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          done_r  <= 1'b0;
          error_r <= 1'b0;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_r;
  assign bus.coin_req  = coin_req_r;
  assign bus.coin_code = coin_code_r;
  assign bus.done      = done_r;
  assign bus.error     = error_r;
  assign bus.residual  = residual_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected coin/done events are queued by
// the driver and popped by an independent monitor as the DUT presents them.
module tb_change_dispenser;
  localparam int AMT_W = 5;
  localparam int W     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  change_dispenser #(
    .AMT_W(AMT_W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks    = 0;
  int failures  = 0;
  bit hopper_en = 1'b1;
  int ack_delay = 2;

  // Event encoding: coin = {6'b0, code}; done = {1'b1, 1'b0, error, residual}.
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_coin(input logic [1:0] code);
    exp_q.push_back({6'b0, code});
  endtask

  task automatic push_done(input logic err, input logic [AMT_W-1:0] res);
    exp_q.push_back({1'b1, 1'b0, err, res});
  endtask

  // Hopper model: acks ack_delay negedges after seeing req, releases after req drops.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.coin_ack) begin
        if (!bus.coin_req) bus.coin_ack = 1'b0;
      end else if (bus.coin_req && hopper_en) begin
        if (wait_cnt >= ack_delay) begin
          bus.coin_ack = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every coin_req rise and every done pulse must match the queue head.
  initial begin
    logic         prev_req;
    logic [W-1:0] got;
    logic [W-1:0] e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.coin_req && !prev_req) begin
        got = {6'b0, bus.coin_code};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_coin actual=%0h required=none", got);
        end else begin
          e = exp_q.pop_front();
          check("coin_event", int'(got), int'(e));
        end
      end
      if (!rst && bus.done) begin
        got = {1'b1, 1'b0, bus.error, bus.residual};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%0h required=none", got);
        end else begin
          e = exp_q.pop_front();
          check("done_event", int'(got), int'(e));
        end
      end
      prev_req = bus.coin_req;
    end
  end

  task automatic send(input logic [AMT_W-1:0] amt);
    int n;
    n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", int'(bus.ready), 1);
    bus.cambio       = amt;
    bus.cambio_valid = 1'b1;
    @(negedge clk);
    bus.cambio_valid = 1'b0;
  endtask

  // Called on the negedge after the accepting edge; returns on the done negedge.
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!bus.done && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check("done_seen", int'(bus.done), 1);
    check("ready_low_at_done", int'(bus.ready), 0);
  endtask

  task automatic after_done(input int res);
    @(negedge clk);
    check("ready_after_done", int'(bus.ready), 1);
    check("done_one_cycle", int'(bus.done), 0);
    check("residual_hold", int'(bus.residual), res);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!bus.coin_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(bus.coin_req), 1);
  endtask

  task automatic txn(input int amt, input int ncoins, input logic [1:0] c0,
                     input logic [1:0] c1, input logic err, input int res,
                     input int exp_cycles);
    int cyc;
    if (ncoins > 0) push_coin(c0);
    if (ncoins > 1) push_coin(c1);
    push_done(err, AMT_W'(res));
    send(AMT_W'(amt));
    wait_done(cyc);
    if (exp_cycles > 0) check("done_latency", cyc, exp_cycles);
    after_done(res);
  endtask

  initial begin
    int cyc;
    bus.cambio       = '0;
    bus.cambio_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(bus.ready), 1);
    check("rst_coin_req", int'(bus.coin_req), 0);
    check("rst_coin_code", int'(bus.coin_code), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_error", int'(bus.error), 0);
    check("rst_residual", int'(bus.residual), 0);
    rst = 1'b0;
    @(negedge clk);

    ack_delay = 2;
    txn(7, 2, 2'b11, 2'b10, 1'b0, 0, 0);
    ack_delay = 0;
    txn(5, 2, 2'b10, 2'b01, 1'b0, 0, 0);
    txn(6, 2, 2'b11, 2'b01, 1'b0, 0, 0);
    txn(2, 1, 2'b01, 2'b00, 1'b0, 0, 0);
    txn(1, 0, 2'b00, 2'b00, 1'b1, 1, 2);
    txn(0, 0, 2'b00, 2'b00, 1'b0, 0, 2);

    // A second strobe while busy is dropped; 9 pays as 4+3+2.
    ack_delay = 2;
    push_coin(2'b11);
    push_coin(2'b10);
    push_coin(2'b01);
    push_done(1'b0, '0);
    send(AMT_W'(9));
    wait_req("busy_req_seen");
    check("ready_low_busy", int'(bus.ready), 0);
    bus.cambio       = AMT_W'(4);
    bus.cambio_valid = 1'b1;
    @(negedge clk);
    bus.cambio_valid = 1'b0;
    wait_done(cyc);
    after_done(0);
    repeat (6) @(negedge clk);

    // Reset while a coin request is outstanding.
    hopper_en = 1'b0;
    push_coin(2'b11);
    send(AMT_W'(9));
    wait_req("rst_req_seen");
    rst = 1'b1;
    @(negedge clk);
    check("midrst_coin_req", int'(bus.coin_req), 0);
    check("midrst_ready", int'(bus.ready), 1);
    check("midrst_done", int'(bus.done), 0);
    rst = 1'b0;
    exp_q.delete();
    hopper_en = 1'b1;
    repeat (5) @(negedge clk);
    txn(4, 1, 2'b11, 2'b00, 1'b0, 0, 0);

`ifdef DISPENSE_TIMEOUT_EN
    // Hopper never acks: request held 16 cycles, then error with full residue.
    hopper_en = 1'b0;
    push_coin(2'b11);
    push_done(1'b1, AMT_W'(7));
    send(AMT_W'(7));
    wait_done(cyc);
    check("timeout_latency", cyc, 18);
    check("timeout_req_dropped", int'(bus.coin_req), 0);
    after_done(7);
    hopper_en = 1'b1;
`endif

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
